// File: rtl/ram_burst_master_if.sv
// Bundle of command, write-stream, read-stream and RAM pin signals for ram_burst_master.
// master = the controller side, slave = the agent/RAM side.
interface ram_burst_master_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
);
  // Every stream uses the same rule: a transfer happens at the rising edge where
  // valid && ready are both 1. Valid never waits for ready, and a producer holds its
  // payload stable while valid=1 and ready=0.
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W-1:0] cmd_len;

  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;

  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;

  logic              done;

  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len,
    input  wr_valid, wr_data,
    input  rd_ready,
    input  ram_rdata,
    output cmd_ready, wr_ready, rd_valid, rd_data, rd_last, done,
    output ram_addr, ram_wdata, ram_we
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len,
    output wr_valid, wr_data,
    output rd_ready,
    output ram_rdata,
    input  cmd_ready, wr_ready, rd_valid, rd_data, rd_last, done,
    input  ram_addr, ram_wdata, ram_we
  );
endinterface

// File: rtl/ram_burst_master.sv
// Burst controller for a single-port RAM with a registered read address.
// Accepts one burst command at a time and streams write or read beats.
module ram_burst_master #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  ram_burst_master_if.master bus,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] beats_left;
  logic              rd_valid_q;
  logic              done_q;

  logic wr_fire;
  logic rd_fire;
  logic last_beat;

  assign wr_fire   = (state == WRITE) && bus.wr_valid;
  assign rd_fire   = rd_valid_q && bus.rd_ready;
  assign last_beat = (beats_left == '0);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cur_addr   <= '0;
      beats_left <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            cur_addr   <= bus.cmd_addr;
            beats_left <= bus.cmd_len;
            rd_valid_q <= 1'b0;
            state      <= bus.cmd_write ? WRITE : READ;
          end
        end
        WRITE: begin
          if (wr_fire) begin
            cur_addr   <= cur_addr + ADDR_W'(1);
            beats_left <= beats_left - ADDR_W'(1);
            if (last_beat) begin
              state  <= IDLE;
              done_q <= 1'b1;
            end
          end
        end
        READ: begin
          // The first READ cycle only presents the start address; data is valid one cycle later.
          if (rd_fire) begin
            cur_addr   <= cur_addr + ADDR_W'(1);
            beats_left <= beats_left - ADDR_W'(1);
            if (last_beat) begin
              state      <= IDLE;
              rd_valid_q <= 1'b0;
              done_q     <= 1'b1;
            end else begin
              rd_valid_q <= 1'b1;
            end
          end else begin
            rd_valid_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.cmd_ready = (state == IDLE);
    bus.wr_ready  = (state == WRITE);
    bus.rd_valid  = rd_valid_q;
    bus.rd_data   = bus.ram_rdata;
    bus.rd_last   = rd_valid_q && last_beat;
    bus.done      = done_q;
    bus.ram_we    = wr_fire;
    bus.ram_wdata = '0;
    bus.ram_addr  = '0;
    case (state)
      WRITE: begin
        bus.ram_wdata = bus.wr_data;
        bus.ram_addr  = cur_addr;
      end
      // Looking one address ahead on accept keeps the next word ready without a bubble;
      // re-presenting cur_addr while stalled holds rd_data stable.
      READ:    bus.ram_addr = rd_fire ? cur_addr + ADDR_W'(1) : cur_addr;
      default: ;
    endcase
  end

endmodule
